// File: rtl/frame_gate_ctrl.sv
// frame_gate_ctrl: admits whole frames from the camera burst stream, decimates
// them, limits how many are forwarded per run and holds the upstream off until
// the downstream sequentializer signals ap_done. The stream itself is purely
// combinational; only control state, counters and sticky flags are registered.
module frame_gate_ctrl #(
    parameter int DATA_WIDTH     = 100,
    parameter int USER_WIDTH     = 2,
    parameter int FRAME_BURSTS   = 40,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  s_axis_resetn,
    input  logic                  cfg_enable,
    input  logic [CNT_WIDTH-1:0]  cfg_num_frames,
    input  logic [7:0]            cfg_decimate,
    input  logic                  cfg_clear,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  seq_ap_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_done,
    output logic [CNT_WIDTH-1:0]  frames_dropped,
    output logic                  timeout_err,
    output logic                  sof_err
);

    localparam int BW = $clog2(FRAME_BURSTS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(FRAME_BURSTS - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_SOF, ST_PASS, ST_DROP, ST_WAIT_DONE, ST_HALT
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q;
    logic [CNT_WIDTH-1:0] remaining_q, num_lat_q;
    logic [7:0]           dec_lat_q, dec_cnt_q, dec_next;
    logic [BW-1:0]        burst_cnt_q;
    logic [WW-1:0]        wd_cnt_q;
    logic [CNT_WIDTH-1:0] frames_done_q, frames_dropped_q;
    logic                 timeout_err_q, sof_err_q;

    logic s_rdy, m_vld, beat, obeat, sof, keep;
    logic lat_cfg, dec_adv, burst_load, burst_inc;
    logic drop_evt, done_evt, to_evt, sof_evt;

    // Saturating increment for the host-visible frame counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tuser  = s_axis_tuser;
    assign s_axis_tready = s_rdy & s_axis_resetn;
    assign m_axis_tvalid = m_vld;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign obeat         = m_axis_tvalid & m_axis_tready;
    assign sof           = s_axis_tuser[0];
    assign keep          = (dec_cnt_q == 8'd0);
    assign dec_next      = (dec_cnt_q == dec_lat_q) ? 8'd0 : dec_cnt_q + 8'd1;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);

    assign frames_done    = frames_done_q;
    assign frames_dropped = frames_dropped_q;
    assign timeout_err    = timeout_err_q;
    assign sof_err        = sof_err_q;

    // Reset release qualifier: async assert, state may move on the second edge after release.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) run_q <= 1'b0;
        else                run_q <= 1'b1;
    end

    // Next-state, stream gating and per-cycle event decode.
    always_comb begin
        state_d    = state_q;
        s_rdy      = 1'b0;
        m_vld      = 1'b0;
        lat_cfg    = 1'b0;
        dec_adv    = 1'b0;
        burst_load = 1'b0;
        burst_inc  = 1'b0;
        drop_evt   = 1'b0;
        done_evt   = 1'b0;
        to_evt     = 1'b0;
        sof_evt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_rdy = 1'b1;
                if (cfg_enable) begin
                    lat_cfg = 1'b1;
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (s_axis_tvalid && sof && keep) begin
                    m_vld = s_axis_tvalid;
                    s_rdy = m_axis_tready;
                    if (obeat) begin
                        burst_load = 1'b1;
                        dec_adv    = 1'b1;
                        state_d    = ST_PASS;
                    end
                end else begin
                    s_rdy = 1'b1;
                    if (beat && sof) begin
                        burst_load = 1'b1;
                        dec_adv    = 1'b1;
                        drop_evt   = 1'b1;
                        state_d    = ST_DROP;
                    end
                end
            end
            ST_PASS: begin
                m_vld = s_axis_tvalid;
                s_rdy = m_axis_tready;
                if (obeat) begin
                    burst_inc = 1'b1;
                    sof_evt   = sof;
                    if (burst_cnt_q == LAST_BURST) state_d = ST_WAIT_DONE;
                end
            end
            ST_DROP: begin
                s_rdy = 1'b1;
                if (beat) begin
                    burst_inc = 1'b1;
                    if (burst_cnt_q == LAST_BURST) state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_DONE: begin
                if (seq_ap_done) begin
                    done_evt = 1'b1;
                    if ((num_lat_q != '0) && (remaining_q == CNT_WIDTH'(1))) state_d = ST_HALT;
                    else if (cfg_enable)                                    state_d = ST_WAIT_SOF;
                    else                                                    state_d = ST_IDLE;
                end else if (wd_cnt_q == WD_LAST) begin
                    to_evt  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                s_rdy = 1'b1;
                if (!cfg_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, frame bookkeeping, counters and sticky flags.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state_q          <= ST_IDLE;
            remaining_q      <= '0;
            num_lat_q        <= '0;
            dec_lat_q        <= '0;
            dec_cnt_q        <= '0;
            burst_cnt_q      <= '0;
            wd_cnt_q         <= '0;
            frames_done_q    <= '0;
            frames_dropped_q <= '0;
            timeout_err_q    <= 1'b0;
            sof_err_q        <= 1'b0;
        end else if (run_q) begin
            state_q <= state_d;
            if (lat_cfg) begin
                remaining_q <= cfg_num_frames;
                num_lat_q   <= cfg_num_frames;
                dec_lat_q   <= cfg_decimate;
                dec_cnt_q   <= '0;
            end else if (dec_adv) begin
                dec_cnt_q <= dec_next;
            end
            if (burst_load)     burst_cnt_q <= BW'(1);
            else if (burst_inc) burst_cnt_q <= burst_cnt_q + 1'b1;
            if (state_q == ST_WAIT_DONE) wd_cnt_q <= wd_cnt_q + 1'b1;
            else                         wd_cnt_q <= '0;
            if (done_evt && (remaining_q != '0)) remaining_q <= remaining_q - 1'b1;
            if (cfg_clear) begin
                frames_done_q    <= '0;
                frames_dropped_q <= '0;
                timeout_err_q    <= 1'b0;
                sof_err_q        <= 1'b0;
            end else begin
                if (done_evt) frames_done_q    <= sat_inc(frames_done_q);
                if (drop_evt) frames_dropped_q <= sat_inc(frames_dropped_q);
                if (to_evt)   timeout_err_q    <= 1'b1;
                if (sof_evt)  sof_err_q        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_gate_ctrl.sv
// Directed bench for frame_gate_ctrl: frame limiting, decimation, output stalls,
// WAIT_DONE watchdog, mid-frame SOF and asynchronous reset mid-frame.
module tb_frame_gate_ctrl;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          s_axis_resetn;
    logic          cfg_enable;
    logic [CW-1:0] cfg_num_frames;
    logic [7:0]    cfg_decimate;
    logic          cfg_clear;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [1:0]    s_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [1:0]    m_axis_tuser;
    logic          seq_ap_done;
    logic          busy;
    logic [CW-1:0] frames_done;
    logic [CW-1:0] frames_dropped;
    logic          timeout_err;
    logic          sof_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic rand_stall = 1'b0;
    logic auto_done  = 1'b1;
    int seq_beats = 0;
    int done_dly  = 0;
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] exp_q[$];

    frame_gate_ctrl #(
        .DATA_WIDTH(DW), .USER_WIDTH(2), .FRAME_BURSTS(40),
        .CNT_WIDTH(CW), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .s_axis_resetn(s_axis_resetn), .cfg_enable(cfg_enable),
        .cfg_num_frames(cfg_num_frames), .cfg_decimate(cfg_decimate), .cfg_clear(cfg_clear),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .seq_ap_done(seq_ap_done), .busy(busy), .frames_done(frames_done),
        .frames_dropped(frames_dropped), .timeout_err(timeout_err), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Downstream ready: always 1, or a coin toss each cycle while stalls are on.
    always @(posedge clk) m_axis_tready <= rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;

    // Output capture.
    always @(posedge clk) if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);

    // Sequentializer stand-in: pulses ap_done about 5 cycles after 40 output beats.
    always @(posedge clk) begin
        seq_ap_done <= 1'b0;
        if (!s_axis_resetn) begin
            seq_beats <= 0;
            done_dly  <= 0;
        end else begin
            if (done_dly != 0) begin
                done_dly <= done_dly - 1;
                if (done_dly == 1) seq_ap_done <= auto_done;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (seq_beats == 39) begin
                    seq_beats <= 0;
                    done_dly  <= 5;
                end else begin
                    seq_beats <= seq_beats + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] u);
        logic acc;
        int   guard;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 400) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            n_chk++;
            $error("FAIL beat_accept: observed no accept expected accept within 400 cycles");
        end
    endtask

    // Frame fid with nb beats; SOF on beat 0 and optionally on beat extra_sof.
    task automatic send_frame(input int fid, input int nb, input int extra_sof);
        for (int i = 0; i < nb; i++)
            send_beat(DW'(fid * 256 + i), (i == 0 || i == extra_sof) ? 2'b01 : 2'b00);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic exp_frame(input int fid);
        for (int i = 0; i < 40; i++) exp_q.push_back(DW'(fid * 256 + i));
    endtask

    task automatic check_stream(input string tag);
        int mism;
        mism = 0;
        chk({tag, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) mism++;
        chk({tag, "_data"}, mism, 0);
    endtask

    task automatic do_reset();
        s_axis_resetn = 1'b0;
        cfg_enable    = 1'b0;
        s_axis_tvalid = 1'b0;
        cyc(3);
        s_axis_resetn = 1'b1;
        cyc(3);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        s_axis_resetn  = 1'b0;
        cfg_enable     = 1'b0;
        cfg_num_frames = '0;
        cfg_decimate   = '0;
        cfg_clear      = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = '0;
        s_axis_tuser   = 2'b01;
        cyc(3);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frames_done, 0);
        chk("rst_dropped", frames_dropped, 0);
        chk("rst_flags", {timeout_err, sof_err}, 0);
        do_reset();

        // Frame limit: 2 of 3 frames forwarded, then HALT flushes the third.
        cfg_num_frames = 16'd2;
        cfg_decimate   = 8'd0;
        cfg_enable     = 1'b1;
        cyc(1);
        chk("t1_busy_run", busy, 1);
        send_frame(1, 40, -1);
        send_frame(2, 40, -1);
        send_frame(3, 40, -1);
        cyc(5);
        exp_frame(1);
        exp_frame(2);
        check_stream("t1");
        chk("t1_done", frames_done, 2);
        chk("t1_busy_halt", busy, 0);
        chk("t1_tready_halt", s_axis_tready, 1);
        cfg_enable = 1'b0;
        cyc(2);
        chk("t1_busy_idle", busy, 0);

        // Clear, then decimation by 3 over six frames with no frame limit.
        cfg_clear = 1'b1;
        cyc(1);
        cfg_clear = 1'b0;
        chk("t2_clear", frames_done, 0);
        out_q.delete();
        exp_q.delete();
        cfg_num_frames = 16'd0;
        cfg_decimate   = 8'd2;
        cfg_enable     = 1'b1;
        cyc(1);
        for (int f = 1; f <= 6; f++) send_frame(10 + f, 40, -1);
        cyc(10);
        exp_frame(11);
        exp_frame(14);
        check_stream("t2");
        chk("t2_dropped", frames_dropped, 4);
        chk("t2_done", frames_done, 2);

        // Random downstream stalls across two forwarded frames.
        do_reset();
        cfg_decimate = 8'd0;
        cfg_enable   = 1'b1;
        rand_stall   = 1'b1;
        cyc(1);
        send_frame(21, 40, -1);
        send_frame(22, 40, -1);
        cyc(12);
        rand_stall = 1'b0;
        exp_frame(21);
        exp_frame(22);
        check_stream("t3");
        chk("t3_done", frames_done, 2);

        // Watchdog: ap_done withheld, flag rises after 100 cycles in WAIT_DONE.
        do_reset();
        auto_done  = 1'b0;
        cfg_enable = 1'b1;
        cyc(1);
        send_frame(31, 40, -1);
        cyc(99);
        chk("t4_to_early", timeout_err, 0);
        chk("t4_hold_tready", s_axis_tready, 0);
        cyc(1);
        chk("t4_to_set", timeout_err, 1);
        chk("t4_idle", busy, 0);
        cfg_clear = 1'b1;
        cyc(1);
        cfg_clear = 1'b0;
        chk("t4_to_clear", timeout_err, 0);

        // Stray SOF at burst 20; frame still closes after 40 bursts.
        do_reset();
        auto_done  = 1'b1;
        cfg_enable = 1'b1;
        cyc(1);
        send_frame(41, 40, 19);
        chk("t5_sof_err", sof_err, 1);
        chk("t5_wait_tready", s_axis_tready, 0);
        chk("t5_len", out_q.size(), 40);
        cyc(8);
        chk("t5_done", frames_done, 1);

        // Async reset at burst 15 of the next frame.
        send_frame(42, 15, -1);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 2'b00;
        s_axis_resetn = 1'b0;
        #1;
        chk("t6_tready", s_axis_tready, 0);
        chk("t6_mvalid", m_axis_tvalid, 0);
        chk("t6_done", frames_done, 0);
        chk("t6_sof_err", sof_err, 0);
        chk("t6_busy", busy, 0);
        s_axis_tvalid = 1'b0;
        cyc(3);
        s_axis_resetn = 1'b1;
        out_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) send_beat(DW'(16'h5500 + i), 2'b00);
        s_axis_tvalid = 1'b0;
        cyc(1);
        chk("t6_nosof_drop", out_q.size(), 0);
        chk("t6_resync_busy", busy, 1);
        send_frame(43, 40, -1);
        cyc(8);
        exp_frame(43);
        check_stream("t6");
        chk("t6_done_after", frames_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
